// File: rtl/reset_seq_pkg.sv
// ============================================================================
// Module  : reset_seq_pkg
// Brief   : Shared types and default 48 MHz cycle constants for the reset
//           sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [1:0] {
    RS_POR          = 2'd0,
    RS_IDLE         = 2'd1,
    RS_RESET        = 2'd2,
    RS_WAIT_RELEASE = 2'd3
  } rs_state_t;

  localparam int unsigned DEB_48M  = 480_000;
  localparam int unsigned POR_48M  = 4_800;
  localparam int unsigned HOLD_48M = 48;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module  : button_debouncer
// Brief   : Two-flop synchroniser and stability-counter debouncer for an
//           active-low pushbutton; button_level is 1 while pressed.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_debouncer
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_48M
) (
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic button_n,
  output logic button_level,
  output logic button_level_nxt
);

  localparam int unsigned c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_mismatch;
  logic               w_flip;

  assign w_mismatch = (~r_sync2) != r_level;
  assign w_flip     = w_mismatch && (r_cnt == c_cnt_last);

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= button_n;
      r_sync2 <= r_sync1;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign button_level     = r_level;
  // Value button_level takes after this edge; lets the POR exit see a same-edge flip.
  assign button_level_nxt = r_level ^ w_flip;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module  : reset_sequencer
// Brief   : Power-on window, debounced manual reset and minimum-width hold
//           driving the SoC manualReset input.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_48M,
  parameter int unsigned POR_CYCLES      = POR_48M,
  parameter int unsigned HOLD_CYCLES     = HOLD_48M
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       button_n,
  output logic       soc_reset,
  output logic       button_level,
  output logic [7:0] press_count
);

  localparam int unsigned c_tmr_w = $clog2(max_u(POR_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [c_tmr_w-1:0] c_por_last  = c_tmr_w'(POR_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_hold_last = c_tmr_w'(HOLD_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_one   = c_tmr_w'(1);

  rs_state_t          r_state;
  rs_state_t          w_state_nxt;
  logic [c_tmr_w-1:0] r_timer;
  logic               r_soc_reset;
  logic [7:0]         r_press_count;
  logic               w_press;
  logic               w_level;
  logic               w_level_nxt;
  logic               w_timing;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_48mhz        (clk_48mhz),
    .reset_n          (reset_n),
    .button_n         (button_n),
    .button_level     (w_level),
    .button_level_nxt (w_level_nxt)
  );

  // RS_IDLE is only ever entered with the button released, so a high level there is a fresh press.
  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    case (r_state)
      RS_POR: begin
        if (r_timer == c_por_last) begin
          w_state_nxt = w_level_nxt ? RS_WAIT_RELEASE : RS_IDLE;
        end
      end
      RS_IDLE: begin
        if (w_level) begin
          w_state_nxt = RS_RESET;
          w_press     = 1'b1;
        end
      end
      RS_RESET: begin
        if (r_timer == c_hold_last) begin
          w_state_nxt = RS_WAIT_RELEASE;
        end
      end
      RS_WAIT_RELEASE: begin
        if (!w_level) begin
          w_state_nxt = RS_IDLE;
        end
      end
      default: w_state_nxt = RS_POR;
    endcase
  end

  assign w_timing = (r_state == RS_POR) || (r_state == RS_RESET);

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RS_POR;
      r_timer       <= '0;
      r_soc_reset   <= 1'b1;
      r_press_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_soc_reset <= (w_state_nxt != RS_IDLE);
      if ((w_state_nxt != r_state) || !w_timing) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + c_tmr_one;
      end
      if (w_press) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign soc_reset    = r_soc_reset;
  assign button_level = w_level;
  assign press_count  = r_press_count;

endmodule

`default_nettype wire
